// File: rtl/fetch_stage.sv
// Instruction fetch + IF/ID register: PC owner, up to DEPTH requests/instructions in flight, epoch-tagged flush on redirect.
// Latency: accept in T with response in T+1 gives IF/ID valid in T+3; issue throttles at DEPTH and imem_req_ready, stall holds IF/ID.
module fetch_stage #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_resp_valid,
    input  logic [DATA_WIDTH-1:0] imem_resp_data,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    input  logic                  stall,
    output logic                  if_id_valid,
    output logic [DATA_WIDTH-1:0] if_id_pc,
    output logic [DATA_WIDTH-1:0] if_id_instruction
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] ins;
    } fetch_t;

    logic [DATA_WIDTH-1:0] pc;
    logic                  epoch;

    logic [DATA_WIDTH-1:0] ifq_pc [DEPTH];
    logic [DEPTH-1:0]      ifq_ep;
    logic [AW-1:0]         ifq_rd, ifq_wr;
    logic [AW:0]           ifq_cnt;

    fetch_t                buf_q [DEPTH];
    logic [AW-1:0]         buf_rd, buf_wr;
    logic [AW:0]           buf_cnt;

    logic [AW+1:0]         occ;
    logic                  req_fire, resp_keep, ifid_upd, buf_pop;

    assign occ            = (AW+2)'(ifq_cnt) + (AW+2)'(buf_cnt);
    assign imem_req_valid = !rst && !redirect_valid && (occ < (AW+2)'(DEPTH));
    assign imem_addr      = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign resp_keep      = imem_resp_valid && !redirect_valid && (ifq_ep[ifq_rd] == epoch);
    assign ifid_upd       = !if_id_valid || !stall;
    assign buf_pop        = ifid_upd && (buf_cnt != '0) && !redirect_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc                <= RESET_PC;
            epoch             <= 1'b0;
            ifq_ep            <= '0;
            ifq_rd            <= '0;
            ifq_wr            <= '0;
            ifq_cnt           <= '0;
            buf_rd            <= '0;
            buf_wr            <= '0;
            buf_cnt           <= '0;
            if_id_valid       <= 1'b0;
            if_id_pc          <= '0;
            if_id_instruction <= NOP;
        end else begin
            if (req_fire) begin
                pc     <= pc + DATA_WIDTH'(4);
                ifq_wr <= ifq_wr + AW'(1);
            end
            if (imem_resp_valid) begin
                ifq_rd <= ifq_rd + AW'(1);
            end
            ifq_cnt <= ifq_cnt + (AW+1)'(req_fire) - (AW+1)'(imem_resp_valid);

            // Every entry already in flight is pre-redirect: stamp it with the
            // outgoing epoch so repeated redirects can never make it look fresh.
            if (redirect_valid) begin
                ifq_ep <= {DEPTH{epoch}};
            end else if (req_fire) begin
                ifq_ep[ifq_wr] <= epoch;
            end

            if (redirect_valid) begin
                pc                <= redirect_pc;
                epoch             <= !epoch;
                buf_rd            <= '0;
                buf_wr            <= '0;
                buf_cnt           <= '0;
                if_id_valid       <= 1'b0;
                if_id_instruction <= NOP;
            end else begin
                if (resp_keep) begin
                    buf_wr <= buf_wr + AW'(1);
                end
                if (buf_pop) begin
                    buf_rd <= buf_rd + AW'(1);
                end
                buf_cnt <= buf_cnt + (AW+1)'(resp_keep) - (AW+1)'(buf_pop);
                if (ifid_upd) begin
                    if_id_valid <= (buf_cnt != '0);
                    if (buf_cnt != '0) begin
                        if_id_pc          <= buf_q[buf_rd].pc;
                        if_id_instruction <= buf_q[buf_rd].ins;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) begin
            ifq_pc[ifq_wr] <= pc;
        end
        if (resp_keep) begin
            buf_q[buf_wr] <= '{pc: ifq_pc[ifq_rd], ins: imem_resp_data};
        end
    end

    resp_has_request: assert property (@(posedge clk) disable iff (rst)
        imem_resp_valid |-> (ifq_cnt != '0));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with an in-order imem model of configurable latency.
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] XK  = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instruction;

    always #5 clk = ~clk;

    fetch_stage #(.DATA_WIDTH(32), .RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .imem_req_valid    (imem_req_valid),
        .imem_req_ready    (imem_req_ready),
        .imem_addr         (imem_addr),
        .imem_resp_valid   (imem_resp_valid),
        .imem_resp_data    (imem_resp_data),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .stall             (stall),
        .if_id_valid       (if_id_valid),
        .if_id_pc          (if_id_pc),
        .if_id_instruction (if_id_instruction)
    );

    int          vec_cnt = 0;
    int          err_cnt = 0;
    int          cyc = 0;
    int          lat = 1;
    int          acc_base;
    int          first;
    logic [31:0] pend_addr [$];
    int          pend_due  [$];
    logic [31:0] acc_addr  [$];
    logic [31:0] log_pc    [$];
    logic [31:0] log_ins   [$];
    int          log_cyc   [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One cycle: present any due response, record accepts and consumed IF/ID, cross the edge.
    task automatic tick();
        if (pend_due.size() != 0 && pend_due[0] == cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = pend_addr[0] ^ XK;
            pend_due.delete(0);
            pend_addr.delete(0);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end
        #1;
        if (imem_req_valid && imem_req_ready) begin
            pend_addr.push_back(imem_addr);
            pend_due.push_back(cyc + lat);
            acc_addr.push_back(imem_addr);
        end
        if (if_id_valid && !stall) begin
            log_pc.push_back(if_id_pc);
            log_ins.push_back(if_id_instruction);
            log_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_model();
        pend_addr.delete();
        pend_due.delete();
        acc_addr.delete();
        log_pc.delete();
        log_ins.delete();
        log_cyc.delete();
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
    endtask

    task automatic do_reset(input int l);
        rst            = 1'b1;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        stall          = 1'b0;
        lat            = l;
        clear_model();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        rst            = 1'b1;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        stall          = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        @(posedge clk);
        #1;
        check("rst_req_valid", 32'(imem_req_valid), 0);
        check("rst_ifid_valid", 32'(if_id_valid), 0);
        check("rst_ifid_pc", if_id_pc, 32'h0);
        check("rst_ifid_ins", if_id_instruction, NOP);
        check("rst_addr", imem_addr, 32'h0);

        // Streaming, 1-cycle latency
        do_reset(1);
        for (int k = 0; k < 3; k++) begin
            check("lat_early_valid", 32'(if_id_valid), 0);
            tick();
        end
        check("lat_c3_valid", 32'(if_id_valid), 1);
        check("lat_c3_pc", if_id_pc, 32'h0);
        check("lat_c3_ins", if_id_instruction, 32'hA5A5_0000);
        run(6);
        check("stream_len", 32'(log_pc.size() >= 5), 1);
        for (int i = 0; i < 5; i++) begin
            check("stream_pc", log_pc[i], 32'(4 * i));
            check("stream_ins", log_ins[i], 32'(4 * i) ^ XK);
            check("stream_cyc", 32'(log_cyc[i]), 32'(3 + i));
        end

        // imem not ready for 3 cycles at pc 8
        do_reset(1);
        run(2);
        imem_req_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("wait_addr", imem_addr, 32'h8);
            check("wait_valid", 32'(imem_req_valid), 1);
            tick();
        end
        imem_req_ready = 1'b1;
        run(6);
        check("wait_acc_len", 32'(acc_addr.size() >= 4), 1);
        check("wait_acc2", acc_addr[2], 32'h8);
        check("wait_acc3", acc_addr[3], 32'hC);
        check("wait_log_len", 32'(log_pc.size() >= 4), 1);
        for (int i = 0; i < 4; i++) check("wait_log_pc", log_pc[i], 32'(4 * i));
        check("wait_log_cyc2", 32'(log_cyc[2]), 8);
        check("wait_log_cyc3", 32'(log_cyc[3]), 9);

        // Decode stall for 5 cycles while holding pc 4
        do_reset(1);
        run(4);
        check("stall_pre_pc", if_id_pc, 32'h4);
        stall    = 1'b1;
        acc_base = acc_addr.size();
        for (int k = 0; k < 5; k++) begin
            tick();
            check("stall_hold_pc", if_id_pc, 32'h4);
            check("stall_hold_valid", 32'(if_id_valid), 1);
        end
        check("stall_accepts", 32'(acc_addr.size() - acc_base), 2);
        stall = 1'b0;
        run(6);
        check("stall_log_len", 32'(log_pc.size() >= 6), 1);
        for (int i = 1; i < 6; i++) begin
            check("stall_log_pc", log_pc[i], 32'(4 * i));
            check("stall_log_cyc", 32'(log_cyc[i]), 32'(8 + i));
        end

        // Redirect with 2 in flight and 1 buffered (2-cycle latency)
        do_reset(2);
        run(6);
        check("redir_pre_pc", if_id_pc, 32'h8);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        tick();
        redirect_valid = 1'b0;
        check("redir_next_valid", 32'(if_id_valid), 0);
        check("redir_next_ins", if_id_instruction, NOP);
        check("redir_next_addr", imem_addr, 32'h100);
        run(7);
        check("redir_log_len", 32'(log_pc.size() >= 5), 1);
        check("redir_log0", log_pc[0], 32'h0);
        check("redir_log1", log_pc[1], 32'h4);
        check("redir_log2", log_pc[2], 32'h8);
        check("redir_log3", log_pc[3], 32'h100);
        check("redir_log3_ins", log_ins[3], 32'h100 ^ XK);
        check("redir_log3_cyc", 32'(log_cyc[3]), 11);
        check("redir_log4", log_pc[4], 32'h104);

        // Back-to-back redirects, 3-cycle latency
        do_reset(3);
        run(6);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        tick();
        redirect_valid = 1'b0;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        tick();
        redirect_valid = 1'b0;
        check("dbl_valid_after", 32'(if_id_valid), 0);
        run(20);
        first = -1;
        for (int i = 0; i < log_pc.size(); i++) begin
            if (first < 0 && log_cyc[i] > 8) first = i;
        end
        check("dbl_found", 32'(first >= 0 && first + 3 <= log_pc.size()), 1);
        if (first >= 0 && first + 3 <= log_pc.size()) begin
            for (int i = 0; i < 3; i++) begin
                check("dbl_pc", log_pc[first + i], 32'h300 + 32'(4 * i));
                check("dbl_ins", log_ins[first + i], (32'h300 + 32'(4 * i)) ^ XK);
            end
        end

        // PC wrap, then reset mid-stream
        do_reset(1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        check("wrap_addr_pre", imem_addr, 32'hFFFF_FFFC);
        tick();
        check("wrap_addr_post", imem_addr, 32'h0);
        run(4);
        check("wrap_log_len", 32'(log_pc.size() >= 2), 1);
        check("wrap_log0", log_pc[0], 32'hFFFF_FFFC);
        check("wrap_log0_ins", log_ins[0], 32'h5A5A_FFFC);
        check("wrap_log1", log_pc[1], 32'h0);
        check("mid_pre_valid", 32'(if_id_valid), 1);
        rst = 1'b1;
        #1;
        check("mid_req_valid", 32'(imem_req_valid), 0);
        check("mid_ifid_valid", 32'(if_id_valid), 0);
        check("mid_ifid_ins", if_id_instruction, NOP);
        check("mid_addr", imem_addr, 32'h0);
        clear_model();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        check("restart_addr", imem_addr, 32'h0);
        run(4);
        check("restart_len", 32'(log_pc.size() >= 1), 1);
        check("restart_pc", log_pc[0], 32'h0);
        check("restart_cyc", 32'(log_cyc[0]), 3);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
